// File: rtl/spike_rate_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : snn_enc_pkg
// Shared encoder FSM states, LFSR constants and fixed-point defaults.
// Rev    : 1.0  initial release
// ============================================================================
package snn_enc_pkg;

  localparam int C_PIX_W_DEF       = 8;
  localparam int C_ENCODE_TIME_DEF = 23;

  localparam logic [15:0] C_LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ENCODE = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/spike_rate_encoder_lfsr.sv
`default_nettype none
// ============================================================================
// Module : spike_lfsr
// Galois LFSR that advances STEPS times per advance pulse; rnd exposes every
// intermediate state, slice k being the state after k+1 single steps.
// Rev    : 1.0  initial release
// ============================================================================
module spike_lfsr #(
  parameter int                LFSR_W = 16,
  parameter int                STEPS  = 16,
  parameter logic [LFSR_W-1:0] SEED   = '1,
  parameter logic [LFSR_W-1:0] TAPS   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  output logic [STEPS*LFSR_W-1:0] rnd
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_chain [STEPS+1];

  assign w_chain[0] = r_state;

  for (genvar gk = 0; gk < STEPS; gk++) begin : g_step
    assign w_chain[gk+1] = {1'b0, w_chain[gk][LFSR_W-1:1]} ^ (w_chain[gk][0] ? TAPS : '0);
    assign rnd[gk*LFSR_W +: LFSR_W] = w_chain[gk+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= SEED;
    end else if (advance) begin
      r_state <= w_chain[STEPS];
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module : spike_rate_encoder
// Loads a frame of pixels and emits ENCODE_TIME rate-coded spike beats.
// Build option: SPIKE_ENC_LFSR_EN selects stochastic LFSR coding instead of
// the deterministic accumulator coding.
// Rev    : 1.0  initial release
// ============================================================================
module spike_rate_encoder
  import snn_enc_pkg::*;
#(
  parameter int NUM_IN      = 16,
  parameter int PIX_W       = C_PIX_W_DEF,
  parameter int ENCODE_TIME = C_ENCODE_TIME_DEF,
  parameter int STEP_W      = 5,
  parameter int LFSR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  input  logic              abort,
  output logic              neuron_clr,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [NUM_IN-1:0] spike_vec,
  output logic [STEP_W-1:0] step_idx,
  output logic              frame_done,
  output logic              busy
);

  localparam int                 C_CNT_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_PIX  = C_CNT_W'(NUM_IN - 1);
  localparam logic [STEP_W-1:0]  C_LAST_STEP = STEP_W'(ENCODE_TIME - 1);

  enc_state_t          r_state;
  logic                r_pix_ready;
  logic                r_neuron_clr;
  logic                r_step_valid;
  logic                r_frame_done;
  logic [NUM_IN-1:0]   r_spike_vec;
  logic [STEP_W-1:0]   r_step_idx;
  logic [C_CNT_W-1:0]  r_pix_cnt;
  logic [PIX_W-1:0]    r_pix [NUM_IN];

  logic                w_accept;
  logic                w_xfer;
  logic                w_last_xfer;
  logic                w_gen;
  logic [STEP_W-1:0]   w_next_idx;
  logic [NUM_IN-1:0]   w_beat;

  assign w_accept    = (r_state == ST_LOAD) && r_pix_ready && pix_valid && !abort;
  assign w_xfer      = r_step_valid && step_ready;
  assign w_last_xfer = w_xfer && (r_step_idx == C_LAST_STEP);
  // A new beat is built when the output register is empty or being drained.
  assign w_gen       = (r_state == ST_ENCODE) && !abort && !w_last_xfer &&
                       (!r_step_valid || step_ready);
  assign w_next_idx  = r_step_valid ? (r_step_idx + 1'b1) : '0;

`ifdef SPIKE_ENC_LFSR_EN
  localparam logic [LFSR_W-1:0] C_SEED = LFSR_W'(C_LFSR_SEED);
  localparam logic [LFSR_W-1:0] C_TAPS = LFSR_W'(C_LFSR_TAPS);

  logic                       w_lfsr_load;
  logic [NUM_IN*LFSR_W-1:0]   w_rnd;

  assign w_lfsr_load = (r_state == ST_CLEAR);

  spike_lfsr #(
    .LFSR_W (LFSR_W),
    .STEPS  (NUM_IN),
    .SEED   (C_SEED),
    .TAPS   (C_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_lfsr_load),
    .advance (w_gen),
    .rnd     (w_rnd)
  );

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign w_beat[gi] = (r_pix[gi] > w_rnd[gi*LFSR_W +: PIX_W]);
  end
`else
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    logic [PIX_W-1:0] r_acc;
    logic [PIX_W:0]   w_sum;

    // Carry out of the phase accumulator is the spike; the remainder wraps.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_pix[gi]};
    assign w_beat[gi] = w_sum[PIX_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
      end else if (abort || (r_state == ST_CLEAR)) begin
        r_acc <= '0;
      end else if (w_gen) begin
        r_acc <= w_sum[PIX_W-1:0];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        r_pix[i] <= '0;
      end
    end else if (w_accept) begin
      r_pix[r_pix_cnt] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_pix_ready  <= 1'b0;
      r_neuron_clr <= 1'b0;
      r_step_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_spike_vec  <= '0;
      r_step_idx   <= '0;
      r_pix_cnt    <= '0;
    end else begin
      r_neuron_clr <= 1'b0;
      r_frame_done <= 1'b0;
      if (abort) begin
        r_state      <= ST_LOAD;
        r_pix_ready  <= 1'b1;
        r_step_valid <= 1'b0;
        r_spike_vec  <= '0;
        r_step_idx   <= '0;
        r_pix_cnt    <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            r_pix_ready <= 1'b1;
            if (w_accept) begin
              if (r_pix_cnt == C_LAST_PIX) begin
                r_pix_cnt    <= '0;
                r_pix_ready  <= 1'b0;
                r_neuron_clr <= 1'b1;
                r_state      <= ST_CLEAR;
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            r_step_idx <= '0;
            r_state    <= ST_ENCODE;
          end
          ST_ENCODE: begin
            if (w_last_xfer) begin
              r_step_valid <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else if (w_gen) begin
              r_step_valid <= 1'b1;
              r_spike_vec  <= w_beat;
              r_step_idx   <= w_next_idx;
            end
          end
          ST_DONE: begin
            r_pix_ready <= 1'b1;
            r_state     <= ST_LOAD;
          end
          default: begin
            r_state <= ST_LOAD;
          end
        endcase
      end
    end
  end

  assign pix_ready  = r_pix_ready;
  assign neuron_clr = r_neuron_clr;
  assign step_valid = r_step_valid;
  assign spike_vec  = r_spike_vec;
  assign step_idx   = r_step_idx;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_spike_rate_encoder
// Scoreboard bench for spike_rate_encoder; SPIKE_ENC_LFSR_EN selects the
// stochastic-coding expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spike_rate_encoder;
  import snn_enc_pkg::*;

  localparam int NUM_IN      = 16;
  localparam int PIX_W       = 8;
  localparam int ENCODE_TIME = 23;
  localparam int STEP_W      = 5;
  localparam int LFSR_W      = 16;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              pix_valid  = 1'b0;
  logic [PIX_W-1:0]  pix_data   = '0;
  logic              abort      = 1'b0;
  logic              step_ready = 1'b1;
  logic              pix_ready;
  logic              neuron_clr;
  logic              step_valid;
  logic [NUM_IN-1:0] spike_vec;
  logic [STEP_W-1:0] step_idx;
  logic              frame_done;
  logic              busy;

  spike_rate_encoder #(
    .NUM_IN      (NUM_IN),
    .PIX_W       (PIX_W),
    .ENCODE_TIME (ENCODE_TIME),
    .STEP_W      (STEP_W),
    .LFSR_W      (LFSR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .abort      (abort),
    .neuron_clr (neuron_clr),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .spike_vec  (spike_vec),
    .step_idx   (step_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_IN-1:0] vec;
    logic [STEP_W-1:0] idx;
  } beat_t;

  beat_t            exp_q[$];
  int               total = 0;
  int               bad   = 0;
  int               clr_cnt, done_cnt, beat_cnt, acc_cnt, first_fire0;
  int               clr_cyc, done_cyc, first_cyc, last_cyc;
  int               spk_cnt [NUM_IN];
  int               ready_mode = 0;
  logic [PIX_W-1:0] frame [NUM_IN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void push_expected();
`ifdef SPIKE_ENC_LFSR_EN
    logic [LFSR_W-1:0] s;
    s = LFSR_W'(C_LFSR_SEED);
    for (int k = 0; k < ENCODE_TIME; k++) begin
      beat_t b;
      b.idx = STEP_W'(k);
      for (int i = 0; i < NUM_IN; i++) begin
        s = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_W'(C_LFSR_TAPS) : '0);
        b.vec[i] = (frame[i] > s[PIX_W-1:0]);
      end
      exp_q.push_back(b);
    end
`else
    for (int k = 0; k < ENCODE_TIME; k++) begin
      beat_t b;
      b.idx = STEP_W'(k);
      for (int i = 0; i < NUM_IN; i++) begin
        int p;
        p = int'(frame[i]);
        b.vec[i] = (((k + 1) * p) >> PIX_W) != ((k * p) >> PIX_W);
      end
      exp_q.push_back(b);
    end
`endif
  endfunction

  // Monitor: pops the scoreboard on every transferred beat.
  initial begin : monitor
    beat_t exp_b;
    beat_t prev_b     = '0;
    bit    prev_stall = 1'b0;
    int    cyc        = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (neuron_clr) begin clr_cnt++;  clr_cyc  = cyc; end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (pix_valid && pix_ready) acc_cnt++;
        if (prev_stall) begin
          check("hold_valid", step_valid, 1);
          check("hold_beat", {spike_vec, step_idx}, prev_b);
        end
        if (step_valid) begin
          check("pix_ready_in_encode", pix_ready, 0);
          if (first_cyc < 0) first_cyc = cyc;
        end
        if (step_valid && step_ready) begin
          beat_cnt++;
          if (step_idx == STEP_W'(ENCODE_TIME - 1)) last_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", exp_q.size(), 1);
          end else begin
            exp_b = exp_q.pop_front();
            check("beat_idx", step_idx, exp_b.idx);
            check("beat_vec", spike_vec, exp_b.vec);
          end
          for (int i = 0; i < NUM_IN; i++) if (spike_vec[i]) spk_cnt[i]++;
          if (spike_vec[0] && first_fire0 < 0) first_fire0 = int'(step_idx);
        end
        prev_stall = step_valid && !step_ready;
        prev_b     = {spike_vec, step_idx};
      end
    end
  end

  initial begin : ready_drv
    int rcyc = 0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      step_ready = (ready_mode == 0) || (rcyc % 3 == 0);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic reset_counts();
    clr_cnt = 0; done_cnt = 0; beat_cnt = 0; acc_cnt = 0; first_fire0 = -1;
    clr_cyc = -1; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    for (int i = 0; i < NUM_IN; i++) spk_cnt[i] = 0;
  endtask

  task automatic send_pix(input logic [PIX_W-1:0] d);
    int guard = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    do begin
      @(negedge clk);
      guard++;
    end while (!pix_ready && guard < 200);
    if (!pix_ready) check("pix_ready_timeout", pix_ready, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic load_pixels(input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      send_pix(frame[i]);
      if (gapped) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_beat(input int idx);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(step_valid && step_idx == STEP_W'(idx)) && guard < 400);
    if (guard >= 400) check("wait_beat_timeout", step_idx, idx);
  endtask

  task automatic run_frame(input bit gapped, input bit hold_valid);
    int guard = 0;
    reset_counts();
    push_expected();
    load_pixels(NUM_IN, gapped);
    if (hold_valid) begin
      pix_valid = 1'b1;
      pix_data  = 8'hA5;
      repeat (12) begin @(posedge clk); #1; end
      pix_valid = 1'b0;
    end
    while (done_cnt == 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt == 0) check("frame_done_timeout", done_cnt, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("clr_pulses", clr_cnt, 1);
    check("done_pulses", done_cnt, 1);
    check("beats", beat_cnt, ENCODE_TIME);
    check("accepts", acc_cnt, NUM_IN);
    check("queue_empty", exp_q.size(), 0);
    check("first_beat_latency", first_cyc - clr_cyc, 2);
    check("done_latency", done_cyc - last_cyc, 1);
  endtask

  task automatic check_counts_a();
    check("cnt_bit0", spk_cnt[0], 22);
    check("cnt_bit1", spk_cnt[1], 11);
    check("cnt_bit2", spk_cnt[2], 5);
    check("cnt_bit3", spk_cnt[3], 0);
    check("bit0_first_fire", first_fire0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step_valid"}, step_valid, 0);
    check({tag, "_neuron_clr"}, neuron_clr, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_spike_vec"}, spike_vec, 0);
    check({tag, "_step_idx"}, step_idx, 0);
  endtask

  task automatic set_frame_a();
    for (int i = 0; i < NUM_IN; i++) frame[i] = '0;
    frame[0] = 8'd255;
    frame[1] = 8'd128;
    frame[2] = 8'd64;
  endtask

  initial begin : stimulus
    reset_counts();
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("pix_ready_after_reset", pix_ready, 1);
    check("busy_after_reset", busy, 0);

`ifdef SPIKE_ENC_LFSR_EN
    for (int i = 0; i < NUM_IN; i++) frame[i] = 8'd255;
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < NUM_IN; i++) check("lfsr_255_rate", spk_cnt[i] >= 20, 1);
    for (int i = 0; i < NUM_IN; i++) frame[i] = 8'd0;
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < NUM_IN; i++) check("lfsr_0_silent", spk_cnt[i], 0);
`else
    // Streaming frame with step_ready held high.
    set_frame_a();
    run_frame(1'b0, 1'b0);
    check_counts_a();

    // Same frame under 1-of-3 backpressure.
    ready_mode = 1;
    run_frame(1'b0, 1'b0);
    check_counts_a();
    ready_mode = 0;

    // Abort at step 10, then the full frame again.
    reset_counts();
    push_expected();
    load_pixels(NUM_IN, 1'b0);
    wait_beat(10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    repeat (30) begin @(posedge clk); #1; end
    check("abort_no_done", done_cnt, 0);
    check("abort_single_clr", clr_cnt, 1);
    check("abort_step_valid", step_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pix_ready", pix_ready, 1);
    run_frame(1'b0, 1'b0);
    check_counts_a();

    // Asynchronous reset after 7 pixels.
    reset_counts();
    load_pixels(7, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_load");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_load_pix_ready", pix_ready, 1);
    run_frame(1'b0, 1'b0);
    check_counts_a();

    // Asynchronous reset mid-encode.
    reset_counts();
    push_expected();
    load_pixels(NUM_IN, 1'b0);
    wait_beat(5);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_encode");
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_encode_pix_ready", pix_ready, 1);
    run_frame(1'b0, 1'b0);
    check_counts_a();

    // Distinct pixels, gapped arrivals, pix_valid held during encode.
    for (int i = 0; i < NUM_IN; i++) frame[i] = PIX_W'(i * 15 + 7);
    run_frame(1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
